// File: rtl/effect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : effect_pkg
// Desc     : Shared constants, FSM encoding and sample helpers for effect_mixer.
// Revision : 1.0 - initial release
// ============================================================================

package effect_pkg;

    localparam int CHOR_BASE    = 256;
    localparam int REV_DELAY    = 4096;
    localparam int LFO_MAX      = 63;
    localparam int LFO_PRESCALE = 512;
    localparam int MIDSCALE     = 2048;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MAIN = 3'd1,
        ST_RD_CHOR = 3'd2,
        ST_RD_REV  = 3'd3,
        ST_CAP_REV = 3'd4,
        ST_MIX     = 3'd5
    } mix_state_t;

    // Offset-binary minus MIDSCALE is just an MSB flip, then sign extension.
    function automatic logic signed [12:0] tap_to_signed(input logic [11:0] x);
        return {~x[11], ~x[11], x[10:0]};
    endfunction

    function automatic logic [11:0] sat_offset(input logic signed [13:0] acc);
        if (acc > 14'sd2047) begin
            return 12'hFFF;
        end else if (acc < -14'sd2048) begin
            return 12'h000;
        end else begin
            return {~acc[11], acc[10:0]};
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/effect_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : effect_mixer_if
// Desc     : Control, sample-memory and output signals of effect_mixer.
// Revision : 1.0 - initial release
// ============================================================================

interface effect_mixer_if
    import effect_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              start;
    logic              chorus_on;
    logic              reverb_on;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_active;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              overrun;

    modport master (
        output start, chorus_on, reverb_on, wr_address, mem_data,
        input  rd_address, rd_active, sample_out, sample_valid, overrun
    );

    modport slave (
        input  start, chorus_on, reverb_on, wr_address, mem_data,
        output rd_address, rd_active, sample_out, sample_valid, overrun
    );

endinterface

`default_nettype wire

// File: rtl/chorus_lfo.sv
`default_nettype none
// ============================================================================
// Module   : chorus_lfo
// Desc     : Prescaled 6-bit triangle generator modulating the chorus delay.
// Revision : 1.0 - initial release
// ============================================================================

module chorus_lfo
    import effect_pkg::*;
#(
    parameter int PRESCALE = LFO_PRESCALE
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [5:0] lfo
);

    localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [c_PRE_W-1:0] r_prescale;
    logic [5:0]         r_lfo;
    logic               r_dir_up;
    logic               w_wrap;

    assign w_wrap = (r_prescale == c_PRE_W'(PRESCALE - 1));

    // Endpoints turn around immediately so neither 0 nor 63 is held twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_lfo      <= '0;
            r_dir_up   <= 1'b1;
        end else if (step) begin
            if (w_wrap) begin
                r_prescale <= '0;
                if (r_dir_up) begin
                    if (r_lfo == 6'(LFO_MAX)) begin
                        r_lfo    <= r_lfo - 6'd1;
                        r_dir_up <= 1'b0;
                    end else begin
                        r_lfo <= r_lfo + 6'd1;
                    end
                end else begin
                    if (r_lfo == 6'd0) begin
                        r_lfo    <= 6'd1;
                        r_dir_up <= 1'b1;
                    end else begin
                        r_lfo <= r_lfo - 6'd1;
                    end
                end
            end else begin
                r_prescale <= r_prescale + c_PRE_W'(1);
            end
        end
    end

    assign lfo = r_lfo;

endmodule

`default_nettype wire

// File: rtl/effect_mixer.sv
`default_nettype none
// ============================================================================
// Module   : effect_mixer
// Desc     : Per-sample mixer reading main/chorus/reverb taps from sample memory.
// Revision : 1.0 - initial release
// ============================================================================

module effect_mixer
    import effect_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LFO_DIV = LFO_PRESCALE
)(
    input  logic          clk,
    input  logic          reset,
    effect_mixer_if.slave bus
);

    mix_state_t        r_state;
    mix_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_chor_delay;
    logic              r_chor_on;
    logic              r_rev_on;
    logic [11:0]       r_main;
    logic [11:0]       r_chor;
    logic [11:0]       r_rev;
    logic [DATA_W-1:0] r_sample_out;
    logic              r_sample_valid;
    logic              r_overrun;

    logic              w_accept;
    logic [ADDR_W-1:0] w_rd_address;
    logic              w_rd_active;
    logic [5:0]        w_lfo;
    logic signed [12:0] w_dm;
    logic signed [12:0] w_dc;
    logic signed [12:0] w_dr;
    logic [13:0]       w_half_c;
    logic [13:0]       w_half_r;
    logic signed [13:0] w_acc;
    logic [11:0]       w_mix;
    logic [DATA_W-13:0] w_unused_mem_hi;

    assign w_accept        = (r_state == ST_IDLE) && bus.start;
    assign w_unused_mem_hi = bus.mem_data[DATA_W-1:12];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_active  = 1'b0;
        w_rd_address = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RD_MAIN;
                end
            end
            ST_RD_MAIN: begin
                w_state_nxt  = ST_RD_CHOR;
                w_rd_active  = 1'b1;
                w_rd_address = r_base;
            end
            ST_RD_CHOR: begin
                w_state_nxt  = ST_RD_REV;
                w_rd_active  = 1'b1;
                w_rd_address = r_base - r_chor_delay;
            end
            ST_RD_REV: begin
                w_state_nxt  = ST_CAP_REV;
                w_rd_active  = 1'b1;
                w_rd_address = r_base - ADDR_W'(REV_DELAY);
            end
            ST_CAP_REV: begin
                w_state_nxt = ST_MIX;
            end
            ST_MIX: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Each capture lands one state after its address, matching the memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base         <= '0;
            r_chor_delay   <= '0;
            r_chor_on      <= 1'b0;
            r_rev_on       <= 1'b0;
            r_main         <= '0;
            r_chor         <= '0;
            r_rev          <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= (r_state == ST_MIX);
            r_overrun      <= bus.start && (r_state != ST_IDLE);
            if (w_accept) begin
                r_base       <= bus.wr_address;
                r_chor_on    <= bus.chorus_on;
                r_rev_on     <= bus.reverb_on;
                r_chor_delay <= ADDR_W'(CHOR_BASE) + ADDR_W'(w_lfo);
            end
            if (r_state == ST_RD_CHOR) begin
                r_main <= bus.mem_data[11:0];
            end
            if (r_state == ST_RD_REV) begin
                r_chor <= bus.mem_data[11:0];
            end
            if (r_state == ST_CAP_REV) begin
                r_rev <= bus.mem_data[11:0];
            end
            if (r_state == ST_MIX) begin
                r_sample_out <= DATA_W'(w_mix);
            end
        end
    end

    assign w_dm     = tap_to_signed(r_main);
    assign w_dc     = tap_to_signed(r_chor);
    assign w_dr     = tap_to_signed(r_rev);
    assign w_half_c = r_chor_on ? {w_dc[12], w_dc[12], w_dc[12:1]} : 14'd0;
    assign w_half_r = r_rev_on  ? {w_dr[12], w_dr[12], w_dr[12:1]} : 14'd0;
    assign w_acc    = $signed({w_dm[12], w_dm} + w_half_c + w_half_r);
    assign w_mix    = sat_offset(w_acc);

    chorus_lfo #(
        .PRESCALE (LFO_DIV)
    ) u_lfo (
        .clk   (clk),
        .reset (reset),
        .step  (r_sample_valid),
        .lfo   (w_lfo)
    );

    assign bus.rd_address   = w_rd_address;
    assign bus.rd_active    = w_rd_active;
    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;
    assign bus.overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_effect_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_effect_mixer
// Desc     : Scoreboard bench for effect_mixer: directed taps, timing and LFO.
// Revision : 1.0 - initial release
// ============================================================================

module tb_effect_mixer;

    typedef struct {
        logic [15:0] smp;
        int          at;
        logic        chk;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a2;
    } exp_t;

    typedef struct {
        logic        chk;
        logic [15:0] ca;
    } expb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t  q_a[$];
    expb_t q_b[$];
    int    q_ovr[$];

    exp_t        a_e;
    expb_t       b_e;
    int          a_idx = 0;
    int          a_bad = 0;
    logic [15:0] a_addr [3];
    int          b_idx = 0;
    logic [15:0] b_cap = '0;
    int          ovr_at;

    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    effect_mixer_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    effect_mixer_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    effect_mixer #(.ADDR_W(16), .DATA_W(16)) u_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    effect_mixer #(.ADDR_W(16), .DATA_W(16), .LFO_DIV(2)) u_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    always @(posedge clk) begin
        bus_a.mem_data <= mem[bus_a.rd_address];
        bus_b.mem_data <= mem[bus_b.rd_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_taps(input logic [15:0] base, input logic [15:0] cdel,
                            input logic [15:0] m, input logic [15:0] c, input logic [15:0] r);
        logic [15:0] ic;
        logic [15:0] ir;
        ic = base - cdel;
        ir = base - 16'h1000;
        mem[base] = m;
        mem[ic]   = c;
        mem[ir]   = r;
    endtask

    // Called on a falling edge; the start is sampled on the next rising edge.
    task automatic issue_a(input logic [15:0] base, input logic ch, input logic rv,
                           input logic [15:0] exp_smp, input logic chk,
                           input logic [15:0] a1, input logic [15:0] a2);
        exp_t e;
        e.smp = exp_smp;
        e.at  = cyc + 6;
        e.chk = chk;
        e.a0  = base;
        e.a1  = a1;
        e.a2  = a2;
        q_a.push_back(e);
        bus_a.wr_address = base;
        bus_a.chorus_on  = ch;
        bus_a.reverb_on  = rv;
        bus_a.start      = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic issue_b(input logic chk, input logic [15:0] ca);
        expb_t e;
        e.chk = chk;
        e.ca  = ca;
        q_b.push_back(e);
        bus_b.wr_address = 16'h7000;
        bus_b.chorus_on  = 1'b1;
        bus_b.reverb_on  = 1'b0;
        bus_b.start      = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor for instance A: sample value, latency, tap addresses, overrun.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            a_idx = 0;
            a_bad = 0;
        end else begin
            if (bus_a.rd_active) begin
                if (a_idx < 3) a_addr[a_idx] = bus_a.rd_address;
                a_idx++;
            end else if (bus_a.rd_address != 16'h0000) begin
                a_bad++;
            end
            if (bus_a.sample_valid) begin
                if (q_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got sample 0x%0h, expected no sample", bus_a.sample_out);
                end else begin
                    a_e = q_a.pop_front();
                    check("sample_out", 32'(bus_a.sample_out), 32'(a_e.smp));
                    check("valid_cycle", cyc, a_e.at);
                    if (a_e.chk) begin
                        check("active_cycles", a_idx, 3);
                        check("idle_addr_nonzero", a_bad, 0);
                        check("addr_main", 32'(a_addr[0]), 32'(a_e.a0));
                        check("addr_chorus", 32'(a_addr[1]), 32'(a_e.a1));
                        check("addr_reverb", 32'(a_addr[2]), 32'(a_e.a2));
                    end
                end
                a_idx = 0;
                a_bad = 0;
            end
            if (bus_a.overrun) begin
                if (q_ovr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_overrun: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    ovr_at = q_ovr.pop_front();
                    check("overrun_cycle", cyc, ovr_at);
                end
            end
        end
    end

    // Monitor for instance B: chorus tap address only.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            b_idx = 0;
        end else begin
            if (bus_b.rd_active) begin
                if (b_idx == 1) b_cap = bus_b.rd_address;
                b_idx++;
            end
            if (bus_b.sample_valid) begin
                if (q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid_b: got sample 0x%0h, expected no sample", bus_b.sample_out);
                end else begin
                    b_e = q_b.pop_front();
                    if (b_e.chk) check("lfo_chorus_addr", 32'(b_cap), 32'(b_e.ca));
                end
                b_idx = 0;
            end
        end
    end

    initial begin
        int s;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0800;
        bus_a.start = 1'b0; bus_a.chorus_on = 1'b0; bus_a.reverb_on = 1'b0; bus_a.wr_address = '0;
        bus_b.start = 1'b0; bus_b.chorus_on = 1'b0; bus_b.reverb_on = 1'b0; bus_b.wr_address = '0;

        repeat (3) @(negedge clk);
        check("rst_sample_out", 32'(bus_a.sample_out), 32'h0);
        check("rst_sample_valid", 32'(bus_a.sample_valid), 32'h0);
        check("rst_overrun", 32'(bus_a.overrun), 32'h0);
        check("rst_rd_active", 32'(bus_a.rd_active), 32'h0);
        check("rst_rd_address", 32'(bus_a.rd_address), 32'h0);
        check("rst_lfo", 32'(u_a.u_lfo.lfo), 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Upper memory bits are garbage and must be ignored.
        set_taps(16'h0100, 16'h0100, 16'h5ABC, 16'h0FFF, 16'h0FFF);
        issue_a(16'h0100, 1'b0, 1'b0, 16'h0ABC, 1'b0, 16'h0, 16'h0);
        set_taps(16'h0010, 16'h0100, 16'h0123, 16'h0FFF, 16'h0000);
        issue_a(16'h0010, 1'b0, 1'b0, 16'h0123, 1'b1, 16'hFF10, 16'hF010);
        set_taps(16'h2000, 16'h0100, 16'h0FFF, 16'h0FFF, 16'h0FFF);
        issue_a(16'h2000, 1'b1, 1'b1, 16'h0FFF, 1'b1, 16'h1F00, 16'h1000);
        set_taps(16'h3000, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        issue_a(16'h3000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0);
        set_taps(16'h4000, 16'h0100, 16'h0900, 16'h0600, 16'h0FFF);
        issue_a(16'h4000, 1'b1, 1'b0, 16'h0800, 1'b0, 16'h0, 16'h0);
        set_taps(16'h5000, 16'h0100, 16'h0800, 16'h0000, 16'h0001);
        issue_a(16'h5000, 1'b0, 1'b1, 16'h0400, 1'b0, 16'h0, 16'h0);
        set_taps(16'h5800, 16'h0100, 16'h0800, 16'h0C00, 16'h0A00);
        issue_a(16'h5800, 1'b1, 1'b1, 16'h0B00, 1'b0, 16'h0, 16'h0);

        // Second start three cycles in is dropped and flagged one cycle later.
        set_taps(16'h0100, 16'h0100, 16'h5ABC, 16'h0FFF, 16'h0FFF);
        s = cyc;
        q_a.push_back('{smp: 16'h0ABC, at: s + 6, chk: 1'b0, a0: 16'h0, a1: 16'h0, a2: 16'h0});
        q_ovr.push_back(s + 4);
        bus_a.wr_address = 16'h0100; bus_a.chorus_on = 1'b0; bus_a.reverb_on = 1'b0;
        bus_a.start = 1'b1;
        @(negedge clk); bus_a.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.wr_address = 16'h0010; bus_a.chorus_on = 1'b1; bus_a.reverb_on = 1'b1;
        @(negedge clk); bus_a.start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset three cycles into a sample must abort it without a strobe.
        set_taps(16'h2000, 16'h0100, 16'h0FFF, 16'h0FFF, 16'h0FFF);
        bus_a.wr_address = 16'h2000; bus_a.chorus_on = 1'b1; bus_a.reverb_on = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk); bus_a.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_sample_out", 32'(bus_a.sample_out), 32'h0);
        check("abort_sample_valid", 32'(bus_a.sample_valid), 32'h0);
        check("abort_rd_active", 32'(bus_a.rd_active), 32'h0);
        check("abort_rd_address", 32'(bus_a.rd_address), 32'h0);
        check("abort_overrun", 32'(bus_a.overrun), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);

        set_taps(16'h5000, 16'h0100, 16'h0800, 16'h0000, 16'h0001);
        issue_a(16'h5000, 1'b0, 1'b1, 16'h0400, 1'b1, 16'h4F00, 16'h4000);

        // LFO steps after the 512th completed sample since reset.
        for (int k = 0; k < 510; k++) begin
            issue_a(16'h0100, 1'b0, 1'b0, 16'h0ABC, 1'b0, 16'h0, 16'h0);
        end
        mem[16'h6000] = 16'h0800;
        mem[16'h5F00] = 16'h0900;
        mem[16'h5EFF] = 16'h0700;
        issue_a(16'h6000, 1'b1, 1'b0, 16'h0880, 1'b1, 16'h5F00, 16'h5000);
        issue_a(16'h6000, 1'b1, 1'b0, 16'h0780, 1'b1, 16'h5EFF, 16'h5000);

        // Instance B steps every 2 samples: bounce at 63 and at 0.
        for (int k = 1; k <= 255; k++) begin
            case (k)
                1, 2, 253: issue_b(1'b1, 16'h6F00);
                3, 255:    issue_b(1'b1, 16'h6EFF);
                127, 128:  issue_b(1'b1, 16'h6EC1);
                129:       issue_b(1'b1, 16'h6EC2);
                default:   issue_b(1'b0, 16'h0000);
            endcase
        end

        repeat (10) @(negedge clk);
        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);
        check("pending_overrun", q_ovr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/effect_mixer.md
EFFECT_MIXER -- requirements
Module: effect_mixer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, sample memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width; samples occupy bits [11:0], offset-binary.
REQ-003 SHALL have ports: clk  in  1  sample-domain clock (fpga_sck).
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-005 SHALL have ports: start  in  1  one-cycle per-sample strobe.
REQ-006 SHALL have ports: chorus_on, reverb_on  in  1 each  effect enables.
REQ-007 SHALL have ports: wr_address  in  ADDR_W  address of newest stored sample.
REQ-008 SHALL have ports: mem_data  in  DATA_W  memory read data, valid one cycle after address.
REQ-009 SHALL have ports: rd_address  out  ADDR_W  memory read address.
REQ-010 SHALL have ports: rd_active  out  1  high while block owns the memory address mux.
REQ-011 SHALL have ports: sample_out  out  DATA_W  mixed sample, {4'b0, 12-bit}.
REQ-012 SHALL have ports: sample_valid  out  1  one-cycle strobe; loads MCU shift register.
REQ-013 SHALL have ports: overrun  out  1  one-cycle pulse, start dropped.

Function
REQ-014 SHALL run FSM IDLE -> RD_MAIN -> RD_CHOR -> RD_REV -> CAP_REV -> MIX -> IDLE, one cycle per non-IDLE state.
REQ-015 SHALL leave IDLE only when start is high; on that edge SHALL latch wr_address (base), chorus_on, reverb_on.
REQ-016 SHALL drive rd_address = base, base-chor_delay, base-REV_DELAY in RD_MAIN, RD_CHOR, RD_REV; subtraction modulo 2^ADDR_W.
REQ-017 SHALL assert rd_active exactly in RD_MAIN, RD_CHOR, RD_REV; rd_address SHALL be 0 otherwise.
REQ-018 SHALL capture mem_data[11:0] as main in RD_CHOR, chorus in RD_REV, reverb in CAP_REV.
REQ-019 SHALL read all three taps every sample regardless of enables; fixed latency.
REQ-020 SHALL convert each tap to 13-bit signed d = x - 2048.
REQ-021 SHALL compute 14-bit signed acc = dm + (chorus_on ? dc>>>1 : 0) + (reverb_on ? dr>>>1 : 0).
REQ-022 SHALL saturate acc to [-2048, 2047], add 2048, zero-extend to DATA_W, register into sample_out in MIX.
REQ-023 SHALL hold sample_out until next MIX; both effects off SHALL give sample_out == main exactly.
REQ-024 SHALL assert sample_valid for one cycle, 6 cycles after the edge where start was sampled.
REQ-025 SHALL ignore start outside IDLE and pulse overrun the following cycle; in-flight sample unaffected.
REQ-026 SHALL use chor_delay = CHOR_BASE + lfo, lfo a 6-bit triangle 0..63.
REQ-027 SHALL step lfo once per LFO_PRESCALE completed samples (counted at sample_valid), up to 63 then down to 0, bouncing; no repeat at the ends.
REQ-028 SHALL latch chor_delay at start; lfo changes mid-sample SHALL NOT affect that sample.

Reset
REQ-029 SHALL on reset force IDLE; sample_out, sample_valid, overrun, rd_active, rd_address = 0.
REQ-030 SHALL reset lfo = 0, direction up, prescaler = 0.
REQ-031 SHALL abort any in-flight sample on reset, with no sample_valid for it.

Structure
REQ-032 SHALL place state enum, CHOR_BASE=256, REV_DELAY=4096, LFO_MAX=63, LFO_PRESCALE=512, MIDSCALE=2048 in package effect_pkg.
REQ-033 SHALL implement the triangle generator and prescaler as sub-module chorus_lfo (inputs: clk, reset, step; output: lfo[5:0]).

Verification
REQ-034 SHALL check reset: all outputs 0, lfo=0; start with both off, main=0x0ABC -> sample_out 0x0ABC, sample_valid at cycle 6.
REQ-035 SHALL check addressing: base 0x0010, lfo=0 -> rd_address 0x0010, 0xFF10, 0xF010 on consecutive cycles, rd_active high for exactly 3 cycles.
REQ-036 SHALL check the mix and saturation cases:
- all taps 0xFFF, both on -> 0x0FFF.
- all taps 0x000, both on -> 0x0000.
- main 0x900, chorus 0x600, chorus only -> 0x0800.
REQ-037 SHALL check overrun: start at cycles 0 and 3 -> one sample_valid at cycle 6, overrun at cycle 4.
REQ-038 SHALL check the LFO:
- after 512 samples, chorus tap at base-257.
- after 63*512 samples, at base-319.
- after 64*512 samples, at base-318.
REQ-039 SHALL check reset at cycle 3 of a sample -> no sample_valid, outputs 0; next start yields a correct sample.
